// File: rtl/jtag_master_if.sv
// jtag_master_if: command/response bundle between the debug
// command path (master) and jtag_master (slave).
interface jtag_master_if #(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = $clog2(MAX_LEN+1)
) ();
   logic               cmd_valid_i;
   logic               cmd_ready_o;
   logic [1:0]         cmd_op_i;
   logic [LEN_W-1:0]   cmd_len_i;
   logic [MAX_LEN-1:0] cmd_data_i;
   logic               rsp_valid_o;
   logic [MAX_LEN-1:0] rsp_data_o;
   logic               busy_o;

   modport master (
      output cmd_valid_i, cmd_op_i, cmd_len_i, cmd_data_i,
      input  cmd_ready_o, rsp_valid_o, rsp_data_o, busy_o
   );

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_len_i, cmd_data_i,
      output cmd_ready_o, rsp_valid_o, rsp_data_o, busy_o
   );
endinterface

// File: rtl/jtag_master.sv
// jtag_master: walks the target TAP through reset/IR/DR/idle steps.
// Define JTAG_CAPTURE_STATE_EN to add the Capture-xR step per scan.
module jtag_master #(
   parameter int TCK_DIV = 4,
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   jtag_master_if.slave bus,
   output logic         tck_o,
   output logic         tms_o,
   output logic         tdi_o,
   output logic         trst_o,
   input  logic         tdo_i
);

   localparam int CNT_W = (TCK_DIV > 1) ? $clog2(2*TCK_DIV) : 1;
   localparam int IDX_W = (MAX_LEN > 8) ? $clog2(MAX_LEN) : 3;
`ifdef JTAG_CAPTURE_STATE_EN
   localparam int PRE_STEPS = 2;
`else
   localparam int PRE_STEPS = 1;
`endif

   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_IR    = 2'b01;
   localparam logic [1:0] OP_RUN   = 2'b11;

   typedef enum logic [3:0] {
      BOOT_RST, IDLE, TLR, SEL_DR, SEL_IR, CAPTURE,
      SHIFT, EXIT1, UPDATE, RTI_RET, RUN, DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [1:0]         op_q, op_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [MAX_LEN-1:0] cap_q, cap_d;
   logic [MAX_LEN-1:0] rsp_q, rsp_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               boot_q, boot_d;
   logic               tck_q, tck_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic               trst_q, trst_d;
   logic               step, step_end, last;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      op_d        = op_q;
      len_d       = len_q;
      data_d      = data_q;
      cap_d       = cap_q;
      rsp_d       = rsp_q;
      rsp_valid_d = 1'b0;
      boot_d      = boot_q;
      tck_d       = tck_q;
      step        = !(state_q inside {IDLE, DONE});
      step_end    = step && (cnt_q == CNT_W'(2*TCK_DIV-1));
      last        = (LEN_W'(idx_q) == len_q - LEN_W'(1));

      // Each step: TCK low for TCK_DIV cycles, then high.
      if (step) begin
         if (step_end) begin
            cnt_d = '0;
            tck_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TCK_DIV-1)) tck_d = 1'b1;
         end
      end

      unique case (state_q)
         IDLE: if (bus.cmd_valid_i) begin
            op_d   = bus.cmd_op_i;
            len_d  = (bus.cmd_len_i > LEN_W'(MAX_LEN)) ?
                     LEN_W'(MAX_LEN) : bus.cmd_len_i;
            data_d = bus.cmd_data_i;
            cap_d  = '0;
            idx_d  = '0;
            cnt_d  = '0;
            tck_d  = 1'b0;
            if (op_d == OP_RESET)   state_d = TLR;
            else if (len_d == '0)   state_d = DONE;
            else if (op_d == OP_RUN) state_d = RUN;
            else                    state_d = SEL_DR;
         end
         BOOT_RST, TLR: if (step_end) begin
            if (idx_q == IDX_W'(4)) begin
               state_d = RTI_RET;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         RTI_RET: if (step_end) state_d = DONE;
         SEL_DR: if (step_end)
            state_d = (op_q == OP_IR) ? SEL_IR : CAPTURE;
         SEL_IR: if (step_end) state_d = CAPTURE;
         CAPTURE: if (step_end) begin
            if (idx_q == IDX_W'(PRE_STEPS-1)) begin
               state_d = SHIFT;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         SHIFT: if (step_end) begin
            cap_d[idx_q] = tdo_i;
            if (last) begin
               state_d = EXIT1;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         EXIT1:  if (step_end) state_d = UPDATE;
         UPDATE: if (step_end) state_d = DONE;
         RUN: if (step_end) begin
            if (last) state_d = DONE;
            else      idx_d   = idx_q + IDX_W'(1);
         end
         DONE: begin
            state_d     = IDLE;
            rsp_valid_d = !boot_q;
            if (!boot_q) rsp_d = cap_q;
            boot_d      = 1'b0;
         end
         default: state_d = BOOT_RST;
      endcase

      // Pins follow the step about to run, so they change with it.
      tms_d  = 1'b0;
      tdi_d  = 1'b0;
      trst_d = 1'b0;
      unique case (state_d)
         BOOT_RST, TLR: begin
            tms_d  = 1'b1;
            trst_d = 1'b1;
         end
         SEL_DR, SEL_IR, EXIT1: tms_d = 1'b1;
         SHIFT: begin
            tms_d = (LEN_W'(idx_d) == len_d - LEN_W'(1));
            tdi_d = data_d[idx_d];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= BOOT_RST;
         cnt_q       <= '0;
         idx_q       <= '0;
         op_q        <= OP_RESET;
         len_q       <= '0;
         data_q      <= '0;
         cap_q       <= '0;
         rsp_q       <= '0;
         rsp_valid_q <= 1'b0;
         boot_q      <= 1'b1;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         trst_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         op_q        <= op_d;
         len_q       <= len_d;
         data_q      <= data_d;
         cap_q       <= cap_d;
         rsp_q       <= rsp_d;
         rsp_valid_q <= rsp_valid_d;
         boot_q      <= boot_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         trst_q      <= trst_d;
      end
   end

   assign bus.cmd_ready_o = (state_q == IDLE);
   assign bus.busy_o      = (state_q != IDLE);
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_data_o  = rsp_q;
   assign tck_o           = tck_q;
   assign tms_o           = tms_q;
   assign tdi_o           = tdi_q;
   assign trst_o          = trst_q;

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: random commands vs. a step-list reference model,
// scoreboarded responses and per-TCK pin checks.
module tb_jtag_master;
   localparam int TD = 2;
   localparam int ML = 32;
   localparam int LW = $clog2(ML+1);
`ifdef JTAG_CAPTURE_STATE_EN
   localparam int PRE = 2;
`else
   localparam int PRE = 1;
`endif

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic tck, tms, tdi, trst;
   logic tdo = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [ML-1:0] data;
      int            acc;
      int            lat;
   } exp_t;

   typedef struct {
      bit tms;
      bit tdi;
      bit trst;
      bit tdo;
   } pin_t;

   exp_t sb[$];
   pin_t pq[$];

   jtag_master_if #(.MAX_LEN(ML), .LEN_W(LW)) bus ();

   jtag_master #(
      .TCK_DIV(TD), .MAX_LEN(ML), .LEN_W(LW)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_ni),
      .bus   (bus),
      .tck_o (tck),
      .tms_o (tms),
      .tdi_o (tdi),
      .trst_o(trst),
      .tdo_i (tdo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (cyc %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic void ps(bit m, bit d, bit r, bit o);
      pin_t p;
      p.tms = m;
      p.tdi = d;
      p.trst = r;
      p.tdo = o;
      pq.push_back(p);
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic void push_reset_steps();
      for (int i = 0; i < 5; i++) ps(1, 0, 1, rb());
      ps(0, 0, 0, rb());
   endfunction

   // Expected TAP steps and response, straight from the TMS recipes.
   function automatic void model(input logic [1:0] op,
                                 input int len,
                                 input logic [ML-1:0] data,
                                 input logic [ML-1:0] tb,
                                 input int acc);
      int L = (len > ML) ? ML : len;
      int n0 = pq.size();
      exp_t e;
      e.data = '0;
      if (op == 2'b00) begin
         push_reset_steps();
      end else if (op == 2'b11) begin
         for (int i = 0; i < L; i++) ps(0, 0, 0, rb());
      end else if (L > 0) begin
         ps(1, 0, 0, rb());
         if (op == 2'b01) ps(1, 0, 0, rb());
         for (int i = 0; i < PRE; i++) ps(0, 0, 0, rb());
         for (int i = 0; i < L; i++) begin
            ps(bit'(i == L-1), data[i], 0, tb[i]);
            e.data[i] = tb[i];
         end
         ps(1, 0, 0, rb());
         ps(0, 0, 0, rb());
      end
      e.acc = acc;
      e.lat = (pq.size() - n0) * 2 * TD + 1;
      sb.push_back(e);
   endfunction

   task automatic issue(input logic [1:0] op, input int len,
                        input logic [ML-1:0] data,
                        input logic [ML-1:0] tb);
      int w = 0;
      bus.cmd_op_i    = op;
      bus.cmd_len_i   = LW'(len);
      bus.cmd_data_i  = data;
      bus.cmd_valid_i = 1'b1;
      while (!bus.cmd_ready_o && w < 4000) begin
         @(negedge clk);
         w++;
      end
      if (!bus.cmd_ready_o) begin
         checks++;
         errors++;
         $display("FAIL accept: ready never rose (cyc %0d)", cyc);
         bus.cmd_valid_i = 1'b0;
         return;
      end
      model(op, len, data, tb, cyc + 1);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      chk("ready_drop", 32'(bus.cmd_ready_o), 0);
   endtask

   task automatic check_reset_vals();
      chk("rst_pins", 32'({tck, tms, tdi, trst}), 32'b0101);
      chk("rst_ctl",
          32'({bus.cmd_ready_o, bus.busy_o, bus.rsp_valid_o}),
          32'b010);
      chk("rst_rsp_data", bus.rsp_data_o, 0);
   endtask

   // Called at a negedge with rst_ni low.
   task automatic boot();
      int k = 0;
      bit seen = 0;
      push_reset_steps();
      rst_ni = 1'b1;
      while (!bus.cmd_ready_o && k < 200) begin
         @(negedge clk);
         k++;
         seen |= bus.rsp_valid_o;
      end
      chk("boot_ready_cycle", 32'(k), 32'(6 * 2 * TD + 1));
      chk("boot_no_rsp", 32'(seen), 0);
      chk("boot_steps_left", 32'(pq.size()), 0);
   endtask

   initial begin : monitor
      logic pt;
      pin_t p;
      exp_t e;
      pt = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_ni) begin
            chk("busy", 32'(bus.busy_o), 32'(!bus.cmd_ready_o));
            if (tck && !pt) begin
               if (pq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tck: unexpected edge (cyc %0d)", cyc);
               end else begin
                  p = pq.pop_front();
                  chk("tms", 32'(tms), 32'(p.tms));
                  chk("tdi", 32'(tdi), 32'(p.tdi));
                  chk("trst", 32'(trst), 32'(p.trst));
                  tdo = p.tdo;
               end
            end
            if (bus.rsp_valid_o) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp: unexpected pulse (cyc %0d)", cyc);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_data", bus.rsp_data_o, e.data);
                  chk("latency", 32'(cyc - e.acc), 32'(e.lat));
               end
            end
         end
         pt = tck;
      end
   end

   initial begin : main
      logic [1:0] op;
      int len;
      int w;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_op_i    = 2'b00;
      bus.cmd_len_i   = '0;
      bus.cmd_data_i  = '0;
      repeat (3) @(negedge clk);
      check_reset_vals();
      boot();

      issue(2'b10, 8, 32'hA5, 32'h3C);
      issue(2'b01, 4, 32'h1, $urandom);
      issue(2'b10, 0, $urandom, $urandom);
      issue(2'b11, 3, $urandom, $urandom);
      issue(2'b00, 0, $urandom, $urandom);
      issue(2'b10, 1, 32'h1, 32'h1);
      issue(2'b01, 40, $urandom, $urandom);

      for (int n = 0; n < 40; n++) begin
         op  = 2'($urandom_range(0, 3));
         len = $urandom_range(0, 35);
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 6)) @(negedge clk);
         issue(op, len, $urandom, $urandom);
      end

      issue(2'b10, 32, $urandom, $urandom);
      repeat (40) @(negedge clk);
      #1 rst_ni = 1'b0;
      #1 check_reset_vals();
      sb.delete();
      pq.delete();
      @(negedge clk);
      boot();
      issue(2'b10, 8, $urandom, $urandom);

      w = 0;
      while ((sb.size() != 0 || pq.size() != 0) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      repeat (2) @(negedge clk);
      chk("drain", 32'(sb.size() + pq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/jtag_master.md
# jtag_master

Host-side JTAG driver: turns single-word scan commands from the on-chip debug/test logic into TCK/TMS/TDI waveforms and returns the TDO bits captured during each shift. It walks the external TAP through reset, IR scans, DR scans and idle cycles, always parking the TAP in Run-Test/Idle between commands. It sits between the debug command path and the JTAG pins of the target `tap_controller`.

## Interface
- `TCK_DIV`, 4: clk cycles per TCK half period, ≥1.
- `MAX_LEN`, 32: maximum scan length in bits, ≥2.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of the length field.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: system clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: master idle; accepts a command.
- `cmd_op_i` in 2: 00 RESET, 01 IR_SCAN, 10 DR_SCAN, 11 RUN_IDLE.
- `cmd_len_i` in LEN_W: scan bit count, or idle TCK count.
- `cmd_data_i` in MAX_LEN: TDI data, LSB shifted first.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_data_o` out MAX_LEN: captured TDO bits, right-aligned.
- `busy_o` out 1: equals `!cmd_ready_o`.
- `tck_o` out 1: JTAG clock to target.
- `tms_o` out 1: JTAG mode select.
- `tdi_o` out 1: JTAG data to target.
- `trst_o` out 1: JTAG reset to target, active high.
- `tdo_i` in 1: JTAG data from target.

## Operation
- FSM states: BOOT_RST, IDLE, TLR (TMS=1 steps), SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RTI_RET, RUN, DONE.
- Each TAP step is one TCK period. TMS/TDI are set at the start of the step, then `tck_o` is low for `TCK_DIV` cycles and high for `TCK_DIV` cycles.
- Handshake: a command is accepted on an edge where `cmd_valid_i && cmd_ready_o`. `cmd_ready_o` is high only in IDLE. It drops on the cycle after acceptance and rises again with the `rsp_valid_o` pulse. A command offered during that pulse is accepted.
- RESET: 5 steps TMS=1 with `trst_o`=1, then 1 step TMS=0 with `trst_o`=0, ending in Run-Test/Idle. Total 6 steps.
- IR_SCAN step TMS sequence: 1, 1, 0, then LEN shift steps with TMS=0 except the last at 1, then 1 (Update), then 0 (back to RTI). Total LEN+5 steps.
- DR_SCAN: same as IR_SCAN minus the second leading 1. Total LEN+4 steps.
- RUN_IDLE: LEN steps, TMS=0, TDI=0.
- Shift data:
  - Shift step i drives `tdi_o`=data[i].
  - `tdo_i` is sampled on the clk edge that drives `tck_o` 1→0 in that step, and stored as `rsp_data_o[i]`.
  - `rsp_data_o` bits at LEN and above read 0. Outside shift steps `tdi_o`=0.
  - For RESET and RUN_IDLE, `rsp_data_o` is set to 0.
- Length rules:
  - LEN=0 for any scan or RUN_IDLE: no TCK edges, and `rsp_valid_o` pulses on the cycle after acceptance.
  - LEN>MAX_LEN is clamped to MAX_LEN.
  - LEN=1: the single shift step carries TMS=1.
- `rsp_data_o` holds its value until the next completion.

## Timing
- Reset values: `tck_o`=0, `tms_o`=1, `tdi_o`=0, `trst_o`=1, `cmd_ready_o`=0, `busy_o`=1, `rsp_valid_o`=0, `rsp_data_o`=0.
- After `rst_ni` rises, a RESET sequence runs automatically, with no `rsp_valid_o` pulse. `cmd_ready_o` rises on the cycle after it completes.
- Latency: for a command of N steps, `rsp_valid_o` is high N·2·TCK_DIV+1 cycles after the accepting edge.
- `rst_ni` asserted mid-command forces all outputs to their reset values asynchronously. The command is dropped with no response, and the automatic RESET sequence runs after release.
- `tck_o`, `tms_o`, `tdi_o` and `trst_o` are driven directly from flops; there is no combinational path from `tdo_i`.

## Configuration
- `JTAG_CAPTURE_STATE_EN`:
  - Defined: IEEE 1149.1 walk. One extra TMS=0 step is inserted between Select-xR and Shift for Capture-xR. Scans take LEN+6 steps (IR) or LEN+5 steps (DR).
  - Undefined: Select-xR goes straight to Shift with TMS=0, matching the in-house TAP, which has no Capture states.

## Test plan
- Reset release, TCK_DIV=2: 5 TCK periods with TMS=1 and `trst_o`=1, then 1 period with TMS=0. `cmd_ready_o` rises on cycle 25 after release.
- DR_SCAN, LEN=8, data 0xA5, target TDO looped from a 0x3C register, capture disabled: TDI bits 1,0,1,0,0,1,0,1. `rsp_valid_o` arrives 49 cycles after acceptance with `rsp_data_o`=0x3C.
- IR_SCAN, LEN=4, data 0x1: TMS sequence 1,1,0,0,0,0,1,1,0. The target TAP asserts SelectIR during shift and ends in RTI.
- LEN=0 DR_SCAN, then RUN_IDLE LEN=3 offered during the pulse: the first returns next cycle with no TCK edges. The second is accepted on the pulse cycle and produces 3 TCK periods with TMS=0.
- `rst_ni` pulsed low mid-shift of a 32-bit DR scan: outputs show reset values immediately, no `rsp_valid_o` pulse follows, and the RESET sequence runs after release.
- With `JTAG_CAPTURE_STATE_EN`, a DR_SCAN of LEN=8 takes 13 steps, giving `rsp_valid_o` at cycle 53 for TCK_DIV=2.
